// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry constants and the {page, x} address packing.
package fb_pkg;
  localparam int FB_COLS = 240;
  localparam int FB_PAGES = 8;
  localparam int FB_ADDR_W = 11;
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [2:0] page, input logic [7:0] x);
    return {page, x};
  endfunction
endpackage

// File: rtl/fb_starve_timer.sv
// fb_starve_timer: counts cycles a requester waits unserved; frc asserts once the limit is reached.
module fb_starve_timer #(
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic frc
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!req || gnt) ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign frc = (cnt_q == LIM);
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port framebuffer RAM owner; scan-out reads win unless the host
// writer has starved, and accepted in-range writes mark their page dirty.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int COLS = FB_COLS,
  parameter int PAGES = FB_PAGES,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [7:0]           rd_x,
  input  logic [2:0]           rd_page,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  input  logic                 wr_valid,
  input  logic [7:0]           wr_x,
  input  logic [2:0]           wr_page,
  input  logic [7:0]           wr_data,
  output logic                 wr_ready,
  output logic [PAGES-1:0]     dirty,
  input  logic [PAGES-1:0]     dirty_clr,
  output logic                 err,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);
  localparam logic [7:0] COLS_B = 8'(COLS);
  logic frc, rd_oob, wr_oob;
  logic rd_valid_q, rd_valid_d, rd_oob_q, rd_oob_d, err_q, err_d;
  logic [PAGES-1:0] dirty_q, dirty_d;
  logic [FB_ADDR_W-1:0] last_q, last_d;
  fb_starve_timer #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_starve (
    .clk, .reset, .req(wr_valid), .gnt(wr_ready), .frc
  );
  always_comb begin
    rd_oob = (rd_x >= COLS_B);
    wr_oob = (wr_x >= COLS_B);
    rd_gnt = rd_req && !(wr_valid && frc);
    wr_ready = wr_valid && !rd_gnt;
    mem_we = wr_ready && !wr_oob;
    mem_wdata = wr_data;
    mem_addr = rd_gnt ? fb_addr(rd_page, rd_x) : wr_ready ? fb_addr(wr_page, wr_x) : last_q;
    last_d = rd_gnt ? mem_addr : last_q;
    rd_valid_d = rd_gnt;
    rd_oob_d = rd_gnt && rd_oob;
    err_d = err_q | (rd_gnt & rd_oob) | (wr_ready & wr_oob);
    dirty_d = (dirty_q & ~dirty_clr) | (mem_we ? PAGES'(1) << wr_page : '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_oob_q <= 1'b0;
      err_q <= 1'b0;
      dirty_q <= '0;
      last_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_oob_q <= rd_oob_d;
      err_q <= err_d;
      dirty_q <= dirty_d;
      last_q <= last_d;
    end
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_oob_q ? 8'h00 : mem_rdata;
  assign err = err_q;
  assign dirty = dirty_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed stimulus with a read-data scoreboard drained by a monitor.
module tb_fb_port_arbiter;
  logic clk = 0, reset = 1;
  logic rd_req = 0, rd_gnt, rd_valid, wr_valid = 0, wr_ready, err, mem_we;
  logic [7:0] rd_x = 0, wr_x = 0, wr_data = 0, rd_data, mem_wdata, mem_rdata;
  logic [2:0] rd_page = 0, wr_page = 0;
  logic [7:0] dirty, dirty_clr = 0;
  logic [10:0] mem_addr;
  logic [7:0] ram [0:2047];
  logic [7:0] exp_q[$];
  int vectors = 0, miscompares = 0;

  fb_port_arbiter dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_x(rd_x), .rd_page(rd_page),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_page(wr_page), .wr_data(wr_data), .wr_ready(wr_ready),
    .dirty(dirty), .dirty_clr(dirty_clr), .err(err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic req, input logic [2:0] p, input logic [7:0] x);
    rd_req = req; rd_page = p; rd_x = x;
  endtask

  task automatic set_wr(input logic v, input logic [2:0] p, input logic [7:0] x, input logic [7:0] d);
    wr_valid = v; wr_page = p; wr_x = x; wr_data = d;
  endtask

  always @(negedge clk)
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    ram[11'h205] = 8'hA5;
    ram[11'h100] = 8'h11;
    ram[11'h0FA] = 8'hEE;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_dirty", dirty, 8'h00);
    chk("reset_err", err, 0);
    // read only
    cyc(); set_rd(1, 3'd2, 8'd5); #1;
    chk("rd_gnt", rd_gnt, 1);
    chk("rd_wr_ready", wr_ready, 0);
    chk("rd_mem_addr", mem_addr, 11'h205);
    chk("rd_mem_we", mem_we, 0);
    exp_q.push_back(8'hA5);
    cyc(); set_rd(0, 3'd0, 8'd0); #1;
    chk("idle_gnt", rd_gnt, 0);
    chk("idle_addr_hold", mem_addr, 11'h205);
    // write only, then read it back
    cyc(); set_wr(1, 3'd3, 8'd239, 8'h3C); #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 11'h3EF);
    chk("wr_mem_wdata", mem_wdata, 8'h3C);
    cyc(); set_wr(0, 3'd0, 8'd0, 8'h00); set_rd(1, 3'd3, 8'd239); #1;
    chk("wr_dirty", dirty, 8'h08);
    chk("wr_err", err, 0);
    exp_q.push_back(8'h3C);
    // contention: forced host win every STARVE_LIMIT+1 cycles
    for (int c = 0; c < 33; c++) begin
      cyc(); set_rd(1, 3'd1, 8'd0); set_wr(1, 3'd4, 8'd7, 8'h77); #1;
      if (c == 15 || c == 31) begin
        chk("starve_rd_gnt", rd_gnt, 0);
        chk("starve_wr_ready", wr_ready, 1);
        chk("starve_mem_addr", mem_addr, 11'h407);
      end else begin
        chk("cont_rd_gnt", rd_gnt, 1);
        chk("cont_wr_ready", wr_ready, 0);
        exp_q.push_back(8'h11);
      end
    end
    cyc(); set_rd(0, 3'd0, 8'd0); set_wr(0, 3'd0, 8'd0, 8'h00); #1;
    chk("cont_dirty", dirty, 8'h18);
    // out-of-range write and read
    cyc(); set_wr(1, 3'd5, 8'd240, 8'h55); #1;
    chk("oob_wr_ready", wr_ready, 1);
    chk("oob_mem_we", mem_we, 0);
    cyc(); set_wr(0, 3'd0, 8'd0, 8'h00); set_rd(1, 3'd0, 8'd250); #1;
    chk("oob_err", err, 1);
    chk("oob_dirty", dirty, 8'h18);
    chk("oob_rd_gnt", rd_gnt, 1);
    exp_q.push_back(8'h00);
    cyc(); set_rd(0, 3'd0, 8'd0); dirty_clr = 8'hFF; #1;
    // dirty set/clear collision
    cyc(); dirty_clr = 8'h00; set_wr(1, 3'd0, 8'd1, 8'h09); #1;
    chk("clr_all_dirty", dirty, 8'h00);
    cyc(); set_wr(0, 3'd0, 8'd0, 8'h00); #1;
    chk("page0_dirty", dirty, 8'h01);
    cyc(); set_wr(1, 3'd0, 8'd2, 8'h0A); dirty_clr = 8'h01; #1;
    chk("coll_wr_ready", wr_ready, 1);
    cyc(); set_wr(0, 3'd0, 8'd0, 8'h00); dirty_clr = 8'h01; #1;
    chk("coll_set_wins", dirty, 8'h01);
    cyc(); dirty_clr = 8'h00; #1;
    chk("coll_clear", dirty, 8'h00);
    // reset while a read is in flight
    cyc(); set_wr(1, 3'd6, 8'd0, 8'h01); #1;
    cyc(); set_wr(1, 3'd6, 8'd1, 8'h02); set_rd(1, 3'd2, 8'd5); #1;
    chk("pre_rst_rd_gnt", rd_gnt, 1);
    cyc(); reset = 1; set_rd(0, 3'd0, 8'd0); set_wr(0, 3'd0, 8'd0, 8'h00); #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_dirty", dirty, 8'h00);
    chk("rst_err", err, 0);
    chk("rst_starve_cnt", dut.u_starve.cnt_q, 0);
    cyc(); reset = 0; #1;
    // out-of-range read alone sets err
    cyc(); set_rd(1, 3'd0, 8'd250); #1;
    chk("oob_rd_mem_we", mem_we, 0);
    exp_q.push_back(8'h00);
    cyc(); set_rd(0, 3'd0, 8'd0); #1;
    chk("rd_oob_err", err, 1);
    repeat (3) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
